// File: rtl/rc522_spi_responder_pkg.sv
// ---------------------------------------------------------------------------
// rc522_pkg
// Shared definitions for the RC522-style SPI register responder:
//   - spi_state_e     : frame-level FSM states
//   - *_REG           : well-known register addresses
//   - *_RST           : register reset values
//   - regResetValue() : reset value of any register address
// ---------------------------------------------------------------------------
package rc522_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } spi_state_e;

  localparam logic [5:0] TX_MODE_REG    = 6'h12;
  localparam logic [5:0] RX_MODE_REG    = 6'h13;
  localparam logic [5:0] TX_CONTROL_REG = 6'h14;
  localparam logic [5:0] VERSION_REG    = 6'h37;

  localparam logic [7:0] DEFAULT_RST    = 8'h00;
  localparam logic [7:0] TX_CONTROL_RST = 8'h80;
  localparam logic [7:0] VERSION_RST    = 8'h92;

  // Only TxControlReg and VersionReg leave reset with a non-zero value.
  function automatic logic [7:0] regResetValue(input int addr);
    logic [7:0] value;
    value = DEFAULT_RST;
    if (addr == int'(TX_CONTROL_REG)) value = TX_CONTROL_RST;
    else if (addr == int'(VERSION_REG)) value = VERSION_RST;
    else if (addr == int'(TX_MODE_REG) || addr == int'(RX_MODE_REG)) value = DEFAULT_RST;
    return value;
  endfunction

endpackage

// File: rtl/rc522_spi_responder_if.sv
// ---------------------------------------------------------------------------
// rc522_spi_responder_if
// SPI bus between a master and the RC522 responder.
//   sclk, ss_n, mosi : driven by the master (mode 0, MSB first, ss_n active low)
//   miso, miso_oe    : driven by the slave
// ---------------------------------------------------------------------------
interface rc522_spi_responder_if;
  logic sclk;
  logic ss_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output ss_n, output mosi, input miso, input miso_oe);
  modport slave  (input sclk, input ss_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/rc522_spi_responder_spi_input_sync.sv
// ---------------------------------------------------------------------------
// spi_input_sync
// Brings the asynchronous SPI inputs into the CLOCK_50 domain and flags
// edges of the synchronized sclk and ss_n.
//   CLOCK_50, reset            : system clock, synchronous active-low reset
//   i_sclk, i_ss_n, i_mosi     : raw SPI pins
//   o_sclk_rise, o_sclk_fall   : one-cycle edge flags of synchronized sclk
//   o_ss_fall, o_ss_rise       : one-cycle edge flags of synchronized ss_n
//   o_ss_n, o_mosi             : synchronized levels
// ---------------------------------------------------------------------------
module spi_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic i_sclk,
  input  logic i_ss_n,
  input  logic i_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_ss_fall,
  output logic o_ss_rise,
  output logic o_ss_n,
  output logic o_mosi
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_ss_prev;

  // Reset to the bus idle state (ss_n high, sclk low) so leaving reset
  // never looks like an edge. The cast-truncated concatenation shifts in
  // the new sample at bit 0 for any depth, including 1.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_ss_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= SYNC_STAGES'({r_sclk_sync, i_sclk});
      r_ss_sync   <= SYNC_STAGES'({r_ss_sync, i_ss_n});
      r_mosi_sync <= SYNC_STAGES'({r_mosi_sync, i_mosi});
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      r_ss_prev   <= r_ss_sync[SYNC_STAGES-1];
    end
  end

  assign o_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  assign o_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_prev;
  assign o_ss_fall   = ~r_ss_sync[SYNC_STAGES-1] & r_ss_prev;
  assign o_ss_rise   = r_ss_sync[SYNC_STAGES-1] & ~r_ss_prev;
  assign o_ss_n      = r_ss_sync[SYNC_STAGES-1];
  assign o_mosi      = r_mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/rc522_spi_responder.sv
// ---------------------------------------------------------------------------
// rc522_spi_responder
// SPI mode-0 slave exposing a 64 x 8 register file in the RC522 frame
// format: address byte {rw, addr[5:0], x}, then one or more data bytes that
// all access the same address (burst).
//   CLOCK_50, reset  : system clock, synchronous active-low reset
//   spi (slave)      : sclk/ss_n/mosi in, miso/miso_oe out
//   i_rd_addr        : local inspection address
//   o_rd_data        : register[i_rd_addr], one cycle latency
//   o_wr_strobe      : one-cycle pulse per committed SPI write
//   o_wr_addr/data   : address/data of the last committed write
//   o_busy           : FSM not in IDLE
//   o_frame_err      : one-cycle pulse when ss_n rises mid-byte
// ---------------------------------------------------------------------------
module rc522_spi_responder
  import rc522_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 6
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  rc522_spi_responder_if.slave spi,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic [7:0]          o_rd_data,
  output logic                o_wr_strobe,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [7:0]          o_wr_data,
  output logic                o_busy,
  output logic                o_frame_err
);

  localparam int REG_COUNT = 2 ** ADDR_W;

  logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise, w_ss_n, w_mosi;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .i_sclk     (spi.sclk),
    .i_ss_n     (spi.ss_n),
    .i_mosi     (spi.mosi),
    .o_sclk_rise(w_sclk_rise),
    .o_sclk_fall(w_sclk_fall),
    .o_ss_fall  (w_ss_fall),
    .o_ss_rise  (w_ss_rise),
    .o_ss_n     (w_ss_n),
    .o_mosi     (w_mosi)
  );

  spi_state_e        r_state, w_next_state;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift_in;
  logic [7:0]        r_shift_out;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_rd_data;
  logic              r_wr_strobe;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_frame_err;

  logic [7:0]        w_byte;
  logic              w_byte_done;
  logic              w_reg_we;
  logic [7:0]        w_regs [REG_COUNT];

  // Byte as it stands once the current mosi bit is shifted in.
  assign w_byte      = {r_shift_in[6:0], w_mosi};
  // ss_n edges take priority over any sclk edge seen in the same cycle.
  assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7) && !w_ss_rise && !w_ss_fall;
  assign w_reg_we    = w_byte_done && (r_state == WDATA) && (r_addr != ADDR_W'(VERSION_REG));

  always_ff @(posedge CLOCK_50) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_ss_rise) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_ss_fall) w_next_state = ADDR;
        ADDR:    if (w_byte_done) w_next_state = w_byte[7] ? RDATA : WDATA;
        default: w_next_state = r_state;
      endcase
    end
  end

  // Register file: one flop group per address so each has its own reset value.
  for (genvar g = 0; g < REG_COUNT; g++) begin : g_reg
    logic [7:0] r_value;
    always_ff @(posedge CLOCK_50) begin
      if (!reset)                                r_value <= regResetValue(g);
      else if (w_reg_we && r_addr == ADDR_W'(g)) r_value <= w_byte;
    end
    assign w_regs[g] = r_value;
  end

  // Bit/byte datapath. On a read, the shift register is reloaded on the
  // sclk fall that follows each completed byte (bit counter back at 0), so
  // bit 7 is on miso before the master's first sampling edge of the byte.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_bit_cnt   <= '0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_addr      <= '0;
      r_rd_data   <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      r_rd_data   <= w_regs[i_rd_addr];
      if (w_ss_fall) begin
        r_bit_cnt   <= '0;
        r_shift_in  <= '0;
        r_shift_out <= '0;
      end else if (w_ss_rise) begin
        if (r_state != IDLE && r_bit_cnt != 3'd0) r_frame_err <= 1'b1;
        r_bit_cnt   <= '0;
        r_shift_out <= '0;
      end else if (r_state != IDLE) begin
        if (w_sclk_rise) begin
          r_shift_in <= w_byte;
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (w_byte_done && r_state == ADDR) r_addr <= ADDR_W'(w_byte[6:1]);
          if (w_reg_we) begin
            r_wr_strobe <= 1'b1;
            r_wr_addr   <= r_addr;
            r_wr_data   <= w_byte;
          end
        end else if (w_sclk_fall && r_state == RDATA) begin
          if (r_bit_cnt == 3'd0) r_shift_out <= w_regs[r_addr];
          else                   r_shift_out <= {r_shift_out[6:0], 1'b0};
        end
      end
    end
  end

  assign spi.miso    = r_shift_out[7];
  assign spi.miso_oe = ~w_ss_n;
  assign o_rd_data   = r_rd_data;
  assign o_wr_strobe = r_wr_strobe;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_busy      = (r_state != IDLE);
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_rc522_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_rc522_spi_responder
// Directed bench for rc522_spi_responder: drives SPI mode-0 frames through
// the bus interface and checks read data, write strobes, frame errors,
// local register inspection and reset behaviour.
// ---------------------------------------------------------------------------
module tb_rc522_spi_responder;

  localparam int HALF = 6;

  logic       CLOCK_50;
  logic       reset;
  logic [5:0] rd_addr;
  logic [7:0] o_rd_data;
  logic       o_wr_strobe;
  logic [5:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_busy;
  logic       o_frame_err;

  int         vecCount;
  int         missCount;
  int         strobeCount;
  int         errCount;
  logic [7:0] rdAtStrobe;

  rc522_spi_responder_if spi ();

  rc522_spi_responder #(.SYNC_STAGES(2), .ADDR_W(6)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .spi        (spi.slave),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (o_rd_data),
    .o_wr_strobe(o_wr_strobe),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_busy     (o_busy),
    .o_frame_err(o_frame_err)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Counts write strobes and frame-error cycles; also captures the local
  // read data seen in the cycle a write commits.
  always @(negedge CLOCK_50) begin
    if (o_wr_strobe) begin
      strobeCount <= strobeCount + 1;
      rdAtStrobe  <= o_rd_data;
    end
    if (o_frame_err) errCount <= errCount + 1;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic readLocal(input logic [5:0] a, output logic [7:0] d);
    rd_addr = a;
    waitCycles(2);
    d = o_rd_data;
  endtask

  // One SPI frame of nBytes; the last byte is cut to lastBits bits. If
  // abortByReset is set, reset is pulsed instead of a clean ss_n release.
  task automatic applyStimulus(input int nBytes, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int lastBits, input bit abortByReset,
                               output logic [7:0] rx1, output logic [7:0] rx2,
                               output logic addrMiso, output logic busyAll, output logic oeAll);
    logic [7:0] tx [3];
    logic [7:0] rx [3];
    int bits;
    tx[0] = b0; tx[1] = b1; tx[2] = b2;
    rx[0] = '0; rx[1] = '0; rx[2] = '0;
    addrMiso = 1'b0; busyAll = 1'b1; oeAll = 1'b1;
    spi.ss_n = 1'b0;
    waitCycles(HALF);
    for (int i = 0; i < nBytes; i++) begin
      bits = (i == nBytes - 1) ? lastBits : 8;
      for (int j = 7; j > 7 - bits; j--) begin
        spi.mosi = tx[i][j];
        waitCycles(HALF);
        spi.sclk = 1'b1;
        rx[i][j] = spi.miso;
        busyAll &= o_busy;
        oeAll &= spi.miso_oe;
        if (i == 0) addrMiso |= spi.miso;
        waitCycles(HALF);
        spi.sclk = 1'b0;
      end
    end
    waitCycles(HALF);
    if (abortByReset) begin
      reset = 1'b0;
      waitCycles(3);
      spi.ss_n = 1'b1;
      waitCycles(3);
      reset = 1'b1;
    end else begin
      spi.ss_n = 1'b1;
    end
    spi.mosi = 1'b0;
    waitCycles(8);
    rx1 = rx[1];
    rx2 = rx[2];
  endtask

  initial begin
    logic [7:0] rx1, rx2, d;
    logic       addrMiso, busyAll, oeAll;
    int         baseS, baseE;

    vecCount = 0; missCount = 0; strobeCount = 0; errCount = 0; rdAtStrobe = '0;
    reset = 1'b0; spi.ss_n = 1'b1; spi.sclk = 1'b0; spi.mosi = 1'b0; rd_addr = 6'h14;
    waitCycles(4);
    checkOutput("rst_busy", 32'(o_busy), 32'h0);
    checkOutput("rst_miso_oe", 32'(spi.miso_oe), 32'h0);
    checkOutput("rst_miso", 32'(spi.miso), 32'h0);
    checkOutput("rst_wr_addr", 32'(o_wr_addr), 32'h0);
    checkOutput("rst_wr_data", 32'(o_wr_data), 32'h0);
    checkOutput("rst_rd_data", 32'(o_rd_data), 32'h0);
    reset = 1'b1;
    waitCycles(2);
    checkOutput("rst_reg14", 32'(o_rd_data), 32'h80);
    readLocal(6'h37, d); checkOutput("rst_reg37", 32'(d), 32'h92);
    readLocal(6'h00, d); checkOutput("rst_reg00", 32'(d), 32'h00);
    checkOutput("rst_no_strobe", 32'(strobeCount), 32'h0);

    // Read TxControlReg.
    applyStimulus(2, 8'hA8, 8'h00, 8'h00, 8, 1'b0, rx1, rx2, addrMiso, busyAll, oeAll);
    checkOutput("rd14_data", 32'(rx1), 32'h80);
    checkOutput("rd14_addr_miso", 32'(addrMiso), 32'h0);
    checkOutput("rd14_busy", 32'(busyAll), 32'h1);
    checkOutput("rd14_oe", 32'(oeAll), 32'h1);
    checkOutput("rd14_busy_after", 32'(o_busy), 32'h0);
    checkOutput("rd14_oe_after", 32'(spi.miso_oe), 32'h0);

    // Write 0x26 to TxModeReg.
    baseS = strobeCount;
    applyStimulus(2, 8'h24, 8'h26, 8'h00, 8, 1'b0, rx1, rx2, addrMiso, busyAll, oeAll);
    checkOutput("wr12_strobes", 32'(strobeCount - baseS), 32'h1);
    checkOutput("wr12_wr_addr", 32'(o_wr_addr), 32'h12);
    checkOutput("wr12_wr_data", 32'(o_wr_data), 32'h26);
    rd_addr = 6'h14;
    waitCycles(2);
    rd_addr = 6'h12;
    checkOutput("wr12_rd_old", 32'(o_rd_data), 32'h80);
    waitCycles(1);
    checkOutput("wr12_rd_new", 32'(o_rd_data), 32'h26);

    // VersionReg is read-only.
    baseS = strobeCount;
    applyStimulus(2, 8'h6E, 8'h55, 8'h00, 8, 1'b0, rx1, rx2, addrMiso, busyAll, oeAll);
    checkOutput("wr37_strobes", 32'(strobeCount - baseS), 32'h0);
    checkOutput("wr37_wr_data", 32'(o_wr_data), 32'h26);
    applyStimulus(2, 8'hEE, 8'h00, 8'h00, 8, 1'b0, rx1, rx2, addrMiso, busyAll, oeAll);
    checkOutput("rd37_data", 32'(rx1), 32'h92);
    readLocal(6'h37, d); checkOutput("rd37_local", 32'(d), 32'h92);

    // Aborted data byte after four bits.
    baseS = strobeCount; baseE = errCount;
    applyStimulus(2, 8'h24, 8'h99, 8'h00, 4, 1'b0, rx1, rx2, addrMiso, busyAll, oeAll);
    checkOutput("abort_frame_err", 32'(errCount - baseE), 32'h1);
    checkOutput("abort_strobes", 32'(strobeCount - baseS), 32'h0);
    readLocal(6'h12, d); checkOutput("abort_reg12", 32'(d), 32'h26);
    applyStimulus(2, 8'hA4, 8'h00, 8'h00, 8, 1'b0, rx1, rx2, addrMiso, busyAll, oeAll);
    checkOutput("abort_next_read", 32'(rx1), 32'h26);
    checkOutput("abort_no_extra_err", 32'(errCount - baseE), 32'h1);

    // Burst write and burst reads.
    baseS = strobeCount;
    applyStimulus(3, 8'h24, 8'h11, 8'h22, 8, 1'b0, rx1, rx2, addrMiso, busyAll, oeAll);
    checkOutput("burst_wr_strobes", 32'(strobeCount - baseS), 32'h2);
    checkOutput("burst_wr_data", 32'(o_wr_data), 32'h22);
    readLocal(6'h12, d); checkOutput("burst_reg12", 32'(d), 32'h22);
    applyStimulus(3, 8'hA8, 8'h00, 8'h00, 8, 1'b0, rx1, rx2, addrMiso, busyAll, oeAll);
    checkOutput("burst_rd14_b1", 32'(rx1), 32'h80);
    checkOutput("burst_rd14_b2", 32'(rx2), 32'h80);
    applyStimulus(3, 8'hA4, 8'h00, 8'h00, 8, 1'b0, rx1, rx2, addrMiso, busyAll, oeAll);
    checkOutput("burst_rd12_b1", 32'(rx1), 32'h22);
    checkOutput("burst_rd12_b2", 32'(rx2), 32'h22);

    // Reset in the middle of a write to 0x2A.
    baseS = strobeCount; baseE = errCount;
    applyStimulus(2, 8'h54, 8'hFF, 8'h00, 4, 1'b1, rx1, rx2, addrMiso, busyAll, oeAll);
    checkOutput("rstabort_strobes", 32'(strobeCount - baseS), 32'h0);
    checkOutput("rstabort_frame_err", 32'(errCount - baseE), 32'h0);
    checkOutput("rstabort_busy", 32'(o_busy), 32'h0);
    checkOutput("rstabort_wr_addr", 32'(o_wr_addr), 32'h0);
    readLocal(6'h2A, d); checkOutput("rstabort_reg2a", 32'(d), 32'h00);
    readLocal(6'h12, d); checkOutput("rstabort_reg12", 32'(d), 32'h00);

    // Next frame works; local read of the same address sees the old value
    // in the cycle the write commits.
    rd_addr = 6'h2A;
    baseS = strobeCount;
    applyStimulus(2, 8'h54, 8'h3C, 8'h00, 8, 1'b0, rx1, rx2, addrMiso, busyAll, oeAll);
    checkOutput("after_rst_strobes", 32'(strobeCount - baseS), 32'h1);
    checkOutput("rbw_old_value", 32'(rdAtStrobe), 32'h00);
    checkOutput("after_rst_wr_addr", 32'(o_wr_addr), 32'h2A);
    readLocal(6'h2A, d); checkOutput("after_rst_reg2a", 32'(d), 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/rc522_spi_responder.md
RC522_SPI_RESPONDER -- requirements
Module: rc522_spi_responder

Interface
REQ-001 Parameters SHALL be: SYNC_STAGES, 2, synchronizer depth for sclk/ss_n/mosi; ADDR_W, 6, register address width (64 registers).
REQ-002 Clock and reset SHALL be: reset, synchronous, active-low; clock CLOCK_50.
REQ-003 CLOCK_50  in  1  50 MHz system clock.
REQ-004 reset  in  1  synchronous active-low reset.
REQ-005 sclk  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0), at most CLOCK_50/8.
REQ-006 ss_n  in  1  slave select, active low.
REQ-007 mosi  in  1  master-out data, MSB first.
REQ-008 miso  out  1  slave-out data, MSB first.
REQ-009 miso_oe  out  1  high while ss_n (synchronized) is low.
REQ-010 rd_addr  in  ADDR_W  local register inspection address.
REQ-011 rd_data  out  8  register[rd_addr], registered, 1-cycle latency.
REQ-012 wr_strobe  out  1  one-cycle pulse on each committed SPI write.
REQ-013 wr_addr / wr_data  out  ADDR_W / 8  address and data of the last committed write.
REQ-014 busy  out  1  high while the FSM is not in IDLE.
REQ-015 frame_err  out  1  one-cycle pulse on an aborted frame.

Function
REQ-016 sclk, ss_n and mosi SHALL pass through SYNC_STAGES flops; edges SHALL be detected on synchronized sclk; total input latency is SYNC_STAGES+1 cycles.
REQ-017 mosi SHALL be sampled on the detected sclk rising edge; miso SHALL change only on the detected sclk falling edge or on ss_n falling.
REQ-018 Frame: byte 0 = address byte {rw, addr[5:0], x}; rw=1 read, rw=0 write; bit 0 ignored.
REQ-019 FSM states SHALL be IDLE, ADDR, WDATA, RDATA, with transitions as follows.
REQ-020 IDLE->ADDR on ss_n falling; bit counter cleared.
REQ-021 ADDR->RDATA or WDATA after 8th rising edge, per rw.
REQ-022 RDATA: shift register loaded with register[addr] on the falling edge after the 8th address bit; miso = bit7 of the shift register.
REQ-023 WDATA: after 8 bits, register[addr] <= byte, and wr_strobe/wr_addr/wr_data update in the same cycle.
REQ-024 Burst: further bytes in the same frame SHALL repeat the access at the same address (write again / reload same register).
REQ-025 ss_n rising SHALL return the FSM to IDLE from any state.
REQ-026 ss_n rising with bit counter in 1..7 SHALL pulse frame_err, discard the partial byte, and perform no write.
REQ-027 miso SHALL be 0 in IDLE and during the address byte.
REQ-028 Same-cycle SPI write and local read to one address SHALL return the old value on rd_data (read-before-write).
REQ-029 Register reset values SHALL be 0x00, except address 0x14 (TxControlReg) = 0x80 and 0x37 (VersionReg) = 0x92.
REQ-030 SPI writes to 0x37 SHALL be ignored: no store and no wr_strobe.

Reset
REQ-031 On reset: FSM=IDLE; counters, shift registers, miso, miso_oe, busy, wr_strobe, frame_err, wr_addr, wr_data and rd_data = 0; register file loaded per REQ-029; synchronizer flops = ss_n high, sclk low, mosi low.
REQ-032 Reset mid-frame SHALL abort the frame without a write and without frame_err; the responder is ready at the next ss_n falling edge after reset deasserts.

Structure
REQ-033 Package rc522_pkg SHALL hold the FSM state enum, register address constants (TxModeReg 0x12, RxModeReg 0x13, TxControlReg 0x14, VersionReg 0x37) and reset-value constants.
REQ-034 One sub-module, spi_input_sync, SHALL implement the synchronizers plus sclk rise/fall and ss_n fall/rise detection.

Verification
REQ-035 After reset, send 0xA8 then 0x00 -> miso returns 0x80; busy high for the frame.
REQ-036 Send 0x24 then 0x26 -> single wr_strobe with wr_addr=0x12, wr_data=0x26; rd_addr=0x12 gives rd_data=0x26 one cycle later.
REQ-037 Send 0x6E then 0x55 (write to 0x37), then read 0xEE -> no wr_strobe, read returns 0x92.
REQ-038 Send 0x24, then raise ss_n after 4 bits of the data byte -> frame_err pulse, register 0x12 unchanged, next frame works.
REQ-039 Burst 0x24, 0x11, 0x22 -> two wr_strobes, final register 0x12 = 0x22; burst read 0xA8, 0x00, 0x00 -> 0x80 twice.
REQ-040 Assert reset during the data bits of a write to 0x2A -> register 0x2A = 0x00, no wr_strobe, no frame_err.
